// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : Shared AES-128 constants and round helper functions.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

    localparam int AES_NR      = 10;
    localparam int AES_BLOCK_W = 128;
    localparam int AES_KEYS_W  = (AES_NR + 1) * AES_BLOCK_W;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // One state column, row 0 in the most significant byte.
    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] w_a0, w_a1, w_a2, w_a3;
        logic [7:0] w_b0, w_b1, w_b2, w_b3;
        w_a0 = col[31:24];
        w_a1 = col[23:16];
        w_a2 = col[15:8];
        w_a3 = col[7:0];
        w_b0 = xtime(w_a0) ^ xtime(w_a1) ^ w_a1 ^ w_a2 ^ w_a3;
        w_b1 = w_a0 ^ xtime(w_a1) ^ xtime(w_a2) ^ w_a2 ^ w_a3;
        w_b2 = w_a0 ^ w_a1 ^ xtime(w_a2) ^ xtime(w_a3) ^ w_a3;
        w_b3 = xtime(w_a0) ^ w_a0 ^ w_a1 ^ w_a2 ^ xtime(w_a3);
        return {w_b0, w_b1, w_b2, w_b3};
    endfunction

    // Byte index k = row + 4*col, byte 0 in the MSBs; row r rotates left by r.
    function automatic logic [AES_BLOCK_W-1:0] shift_rows(input logic [AES_BLOCK_W-1:0] s);
        logic [AES_BLOCK_W-1:0] w_res;
        w_res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                w_res[AES_BLOCK_W-1-8*(r+4*c) -: 8] = s[AES_BLOCK_W-1-8*(r+4*((c+r)%4)) -: 8];
            end
        end
        return w_res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_encrypt_if.sv
`default_nettype none
// ============================================================================
// Module      : aes_encrypt_if
// Description : Data/key/handshake bundle between sequencer and cipher core.
// Revision    : 1.0 - initial release
// ============================================================================
interface aes_encrypt_if;
    import aes_pkg::*;

    logic [AES_BLOCK_W-1:0] data_in;
    logic [AES_KEYS_W-1:0]  all_keys;
    logic                   enable;
    logic [AES_BLOCK_W-1:0] data_out;
    logic                   done;

    modport master (
        output data_in,
        output all_keys,
        output enable,
        input  data_out,
        input  done
    );

    modport slave (
        input  data_in,
        input  all_keys,
        input  enable,
        output data_out,
        output done
    );

endinterface
`default_nettype wire

// File: rtl/aes_sbox.sv
`default_nettype none
// ============================================================================
// Module      : aes_sbox
// Description : Combinational forward AES S-box, 256-entry lookup table.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_sbox (
    input  wire logic [7:0] i_byte,
    output logic      [7:0] o_byte
);

    // Entry 0 occupies the MSBs; entry a sits at bit offset 8*(255-a).
    localparam logic [2047:0] c_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign o_byte = c_SBOX[{~i_byte, 3'b000} +: 8];

endmodule
`default_nettype wire

// File: rtl/aes_encrypt.sv
`default_nettype none
// ============================================================================
// Module      : aes_encrypt
// Description : Iterative AES-128 encryption core, one round per enabled clock.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_encrypt
    import aes_pkg::*;
#(
    parameter int NR = AES_NR
) (
    input  wire logic    clk,
    input  wire logic    rst,
    aes_encrypt_if.slave bus
);

    localparam logic [3:0] c_LAST_RC = 4'(NR);

    logic [3:0]             r_rc;
    logic [AES_BLOCK_W-1:0] r_state;
    logic                   r_done;

    logic [AES_BLOCK_W-1:0] w_sub;
    logic [AES_BLOCK_W-1:0] w_shift;
    logic [AES_BLOCK_W-1:0] w_mix;
    logic [AES_BLOCK_W-1:0] w_rk;
    logic [AES_BLOCK_W-1:0] w_next;

    for (genvar i = 0; i < 16; i++) begin : g_sbox
        aes_sbox u_sbox (
            .i_byte (r_state[AES_BLOCK_W-1-8*i -: 8]),
            .o_byte (w_sub[AES_BLOCK_W-1-8*i -: 8])
        );
    end

    assign w_shift = shift_rows(w_sub);

    for (genvar c = 0; c < 4; c++) begin : g_mix
        assign w_mix[AES_BLOCK_W-1-32*c -: 32] = mix_column(w_shift[AES_BLOCK_W-1-32*c -: 32]);
    end

    // Round key rc sits at the MSB end of the key bus for rc = 0.
    always_comb begin
        w_rk = '0;
        for (int i = 0; i <= NR; i++) begin
            if (r_rc == 4'(i)) begin
                w_rk = bus.all_keys[AES_KEYS_W-1-AES_BLOCK_W*i -: AES_BLOCK_W];
            end
        end
    end

    always_comb begin
        w_next = w_mix ^ w_rk;
        if (r_rc == 4'd0) begin
            w_next = bus.data_in ^ w_rk;
        end else if (r_rc == c_LAST_RC) begin
            w_next = w_shift ^ w_rk;
        end
    end

    // Once done, the counter parks at NR+1 and the ciphertext holds until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rc    <= 4'd0;
            r_state <= '0;
            r_done  <= 1'b0;
        end else if (bus.enable && !r_done) begin
            r_state <= w_next;
            r_rc    <= r_rc + 4'd1;
            if (r_rc == c_LAST_RC) begin
                r_done <= 1'b1;
            end
        end
    end

    assign bus.data_out = r_state;
    assign bus.done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_aes_encrypt.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_encrypt
// Description : Self-checking bench for aes_encrypt against a byte-level AES model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_encrypt;
    import aes_pkg::*;

    typedef struct {
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
    } vec_t;

    localparam logic [127:0] c_C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] c_C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] c_C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    logic [7:0] sb [256];

    aes_encrypt_if bus ();

    aes_encrypt #(.NR(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
        logic [7:0] v;
        v = b;
        for (int i = 0; i < k; i++) v = {v[6:0], v[7]};
        return v;
    endfunction

    // S-box derived from first principles: GF(2^8) inverse then affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int x = 1; x < 256; x++) begin
                if (gmul(8'(a), 8'(x)) == 8'h01) inv = 8'(x);
            end
            sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [AES_KEYS_W-1:0] expand_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rcon;
        logic [AES_KEYS_W-1:0] ks;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rcon, 24'h0};
                rcon = gmul(rcon, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        ks = '0;
        for (int i = 0; i < 44; i++) ks[AES_KEYS_W-1-32*i -: 32] = w[i];
        return ks;
    endfunction

    // Expected data_out after n enabled edges (n = 0..11) from reset.
    function automatic logic [127:0] ref_state(input logic [AES_KEYS_W-1:0] ks,
                                               input logic [127:0] pt, input int n);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] a0, a1, a2, a3;
        logic [127:0] v;
        if (n == 0) return '0;
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ ks[AES_KEYS_W-1-8*i -: 8];
        for (int rnd = 1; rnd < n && rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    s[r+4*c] = t[r+4*((c+r)%4)];
            if (rnd != 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ ks[AES_KEYS_W-1-128*rnd-8*i -: 8];
        end
        for (int i = 0; i < 16; i++) v[127-8*i -: 8] = s[i];
        return v;
    endfunction

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.enable = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic load(input logic [127:0] key, input logic [127:0] pt);
        bus.all_keys = expand_key(key);
        bus.data_in  = pt;
    endtask

    vec_t tbl [3];

    initial begin
        logic [AES_KEYS_W-1:0] ks;
        logic [127:0] key, pt, frozen;
        int n;
        int cyc;

        checks = 0;
        failures = 0;
        rst = 1'b1;
        bus.enable = 1'b0;
        bus.data_in = '0;
        bus.all_keys = '0;
        build_sbox();

        tbl[0] = '{key: c_C1_KEY, pt: c_C1_PT, ct: c_C1_CT};
        tbl[1] = '{key: 128'h0, pt: 128'h0, ct: 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};
        tbl[2] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                   pt:  128'h3243f6a8885a308d313198a2e0370734,
                   ct:  128'h3925841d02dc09fbdc118597196a0b32};

        // Reset state
        do_reset();
        check("reset_data_out", bus.data_out, 128'h0);
        check("reset_done", {127'h0, bus.done}, 128'h0);

        // C.1 walk-through; data_in changes after edge 1 must not matter
        load(c_C1_KEY, c_C1_PT);
        bus.enable = 1'b1;
        tick();
        check("c1_edge1", bus.data_out, 128'h00102030405060708090a0b0c0d0e0f0);
        bus.data_in = 128'hdeadbeef_cafef00d_01234567_89abcdef;
        tick();
        check("c1_edge2", bus.data_out, 128'h89d810e8855ace682d1843d8cb128fe4);
        repeat (8) tick();
        check("c1_edge10_done_low", {127'h0, bus.done}, 128'h0);
        tick();
        check("c1_edge11_ct", bus.data_out, c_C1_CT);
        check("c1_edge11_done", {127'h0, bus.done}, 128'h1);

        // Hold after done with new data_in and enable high
        bus.data_in = 128'h0f0e0d0c0b0a09080706050403020100;
        repeat (10) tick();
        check("hold_after_done_ct", bus.data_out, c_C1_CT);
        check("hold_after_done_flag", {127'h0, bus.done}, 128'h1);

        // Known-answer table
        for (int v = 0; v < 3; v++) begin
            do_reset();
            load(tbl[v].key, tbl[v].pt);
            bus.enable = 1'b1;
            repeat (11) tick();
            check($sformatf("kat%0d_ct", v), bus.data_out, tbl[v].ct);
            check($sformatf("kat%0d_done", v), {127'h0, bus.done}, 128'h1);
        end

        // Five-cycle enable gap after edge 4
        do_reset();
        load(c_C1_KEY, c_C1_PT);
        bus.enable = 1'b1;
        repeat (4) tick();
        frozen = bus.data_out;
        check("gap_edge4", frozen, ref_state(bus.all_keys, c_C1_PT, 4));
        bus.enable = 1'b0;
        repeat (5) tick();
        check("gap_frozen", bus.data_out, frozen);
        check("gap_done_low", {127'h0, bus.done}, 128'h0);
        bus.enable = 1'b1;
        repeat (7) tick();
        check("gap_ct", bus.data_out, c_C1_CT);
        check("gap_done", {127'h0, bus.done}, 128'h1);

        // Reset at edge 6 together with enable, then restart
        do_reset();
        load(c_C1_KEY, c_C1_PT);
        bus.enable = 1'b1;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        check("midreset_data_out", bus.data_out, 128'h0);
        check("midreset_done", {127'h0, bus.done}, 128'h0);
        rst = 1'b0;
        repeat (10) tick();
        check("restart_not_done", {127'h0, bus.done}, 128'h0);
        tick();
        check("restart_ct", bus.data_out, c_C1_CT);
        check("restart_done", {127'h0, bus.done}, 128'h1);

        // Random keys/plaintexts with random enable gaps, checked every cycle
        for (int it = 0; it < 12; it++) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            pt  = {$urandom, $urandom, $urandom, $urandom};
            do_reset();
            load(key, pt);
            ks = bus.all_keys;
            n = 0;
            cyc = 0;
            while (n < 14 && cyc < 200) begin
                bus.enable = ($urandom_range(0, 3) != 0);
                if (n > 0) bus.data_in = {$urandom, $urandom, $urandom, $urandom};
                tick();
                if (bus.enable && n < 14) n++;
                cyc++;
                check($sformatf("rand%0d_state_n%0d", it, n), bus.data_out,
                      ref_state(ks, pt, (n > 11) ? 11 : n));
                check($sformatf("rand%0d_done_n%0d", it, n), {127'h0, bus.done},
                      {127'h0, (n >= 11)});
            end
            if (n < 14) check($sformatf("rand%0d_timeout", it), 128'(n), 128'd14);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
